// File: rtl/check_lag_pkg.sv
// check_lag_pkg
//   Shared definitions for the lag-capture block: the measurement state type
//   and the bit positions used in the software latch register and the
//   readback word.
//   Ports: none (package only).
//   Configuration macro: CHECK_LAG_AUTO_REARM_EN (consumed by check_lag_capture).

package check_lag_pkg;

  // Measurement sequence: idle, armed and waiting for the reference pulse,
  // counting towards the data pulse, and holding a finished result.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REF = 2'd1,
    COUNT    = 2'd2,
    DONE     = 2'd3
  } lag_state_e;

  // Software latch register bits.
  localparam int ARM_BIT   = 0;
  localparam int CLR_BIT   = 1;

  // Readback word flag bits.
  localparam int VALID_BIT = 31;
  localparam int OVF_BIT   = 30;

endpackage

// File: rtl/check_lag_edge.sv
// check_lag_edge
//   Registered rising-edge detector for the software arm bit. The pulse
//   appears one cycle after the rising edge is sampled, so the consumer acts
//   on it the cycle after the edge.
//   Ports:
//     clk_i    - clock
//     rst_ni   - synchronous active-low reset
//     level_i  - level input to watch
//     rise_o   - one-cycle registered pulse on a 0->1 transition of level_i
//   Configuration macro: none (CHECK_LAG_AUTO_REARM_EN is handled by the top).

module check_lag_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;
  logic rise_q;

  // The history register tracks the input even while reset is held, so a
  // bit that is already high when reset releases is not mistaken for a new
  // rising edge. The pulse register itself is cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      level_q <= level_i;
      rise_q  <= 1'b0;
    end else begin
      level_q <= level_i;
      rise_q  <= level_i & ~level_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/check_lag_capture.sv
// check_lag_capture
//   Measures the number of clock cycles between a reference sync pulse and
//   the following data-stream sync pulse, after being armed by software.
//   Ports:
//     user_clk   - single clock
//     user_rst_n - synchronous active-low reset
//     latch_reg  - software latch register; bit 0 arm (rising edge),
//                  bit 1 clear (level), other bits ignored
//     ref_sync   - reference sync pulse
//     dat_sync   - data-stream sync pulse
//     lag_out    - readback: bit 31 valid, bit 30 overflow,
//                  bits CNT_W-1:0 lag, other bits zero
//     busy       - high while waiting for the reference or counting
//   Parameters:
//     CNT_W   - counter / lag field width (8..28)
//     TIMEOUT - elapsed count at which a measurement aborts with overflow
//   Configuration macro:
//     CHECK_LAG_AUTO_REARM_EN - when defined, DONE lasts one cycle and the
//     block rearms itself, keeping the last result visible until the next
//     result replaces it.

module check_lag_capture
  import check_lag_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic [31:0] latch_reg,
  input  logic        ref_sync,
  input  logic        dat_sync,
  output logic [31:0] lag_out,
  output logic        busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  lag_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lag_q;
  logic             valid_q;
  logic             ovf_q;
  logic             busy_q;
  logic             armRise;
  logic             unusedLatchBits;

  assign unusedLatchBits = ^latch_reg[31:2];

  check_lag_edge u_arm_edge (
    .clk_i   (user_clk),
    .rst_ni  (user_rst_n),
    .level_i (latch_reg[ARM_BIT]),
    .rise_o  (armRise)
  );

  // Measurement controller. Priority is reset, then the clear level, then a
  // fresh arm event, then the normal state progression. The counter holds
  // the number of cycles elapsed since the reference pulse, so a data pulse
  // k cycles after the reference reports lag k. The counter stops at
  // TIMEOUT; if no data pulse arrives on that cycle the result is the
  // saturated count flagged as overflow. Busy is registered alongside the
  // state so it tracks WAIT_REF/COUNT without decoding.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lag_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (latch_reg[CLR_BIT]) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lag_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (armRise) begin
      state_q <= WAIT_REF;
      cnt_q   <= '0;
      lag_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
        end
        WAIT_REF: begin
          if (ref_sync && dat_sync) begin
            state_q <= DONE;
            lag_q   <= '0;
            valid_q <= 1'b1;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (ref_sync) begin
            state_q <= COUNT;
            cnt_q   <= CNT_ONE;
          end
        end
        COUNT: begin
          if (dat_sync) begin
            state_q <= DONE;
            lag_q   <= cnt_q;
            valid_q <= 1'b1;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (cnt_q == TIMEOUT_CNT) begin
            state_q <= DONE;
            lag_q   <= TIMEOUT_CNT;
            valid_q <= 1'b1;
            ovf_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        DONE: begin
`ifdef CHECK_LAG_AUTO_REARM_EN
          // Result registers are left alone so the last lag stays readable.
          state_q <= WAIT_REF;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
`else
          // Terminal until software arms again or clears.
          state_q <= DONE;
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Readback word is pure wiring of the registered result fields.
  always_comb begin
    lag_out            = '0;
    lag_out[CNT_W-1:0] = lag_q;
    lag_out[OVF_BIT]   = ovf_q;
    lag_out[VALID_BIT] = valid_q;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_check_lag_capture.sv
// tb_check_lag_capture
//   Self-checking bench for check_lag_capture. Directed scenarios followed by
//   a randomized run, all compared every cycle against a cycle-accounting
//   reference model (elapsed cycles since the reference pulse).
//   Configuration macro: CHECK_LAG_AUTO_REARM_EN (enables the auto-rearm
//   scenario and model behaviour).

module tb_check_lag_capture;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;

  logic        user_clk   = 1'b0;
  logic        user_rst_n = 1'b0;
  logic [31:0] latch_reg  = '0;
  logic        ref_sync   = 1'b0;
  logic        dat_sync   = 1'b0;
  logic [31:0] lag_out;
  logic        busy;

  check_lag_capture #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .latch_reg  (latch_reg),
    .ref_sync   (ref_sync),
    .dat_sync   (dat_sync),
    .lag_out    (lag_out),
    .busy       (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 user_clk = ~user_clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: abstract flags plus the cycle number of the
  // reference pulse; the lag is the difference of cycle numbers.
  int cyc        = 0;
  bit mPrevArm   = 1'b0;
  bit mPend      = 1'b0;
  bit mWaiting   = 1'b0;
  bit mMeasuring = 1'b0;
  bit mValid     = 1'b0;
  bit mOvf       = 1'b0;
  int mRefAt     = 0;
  int mLag       = 0;
  int mRearmAt   = -1;

  // Records a finished measurement in the model.
  function automatic void finishMeasure(input int lag, input bit ovf);
    mWaiting   = 1'b0;
    mMeasuring = 1'b0;
    mLag       = lag;
    mValid     = 1'b1;
    mOvf       = ovf;
`ifdef CHECK_LAG_AUTO_REARM_EN
    mRearmAt   = cyc + 1;
`endif
  endfunction

  // Advances the model by one clock edge using the inputs seen at that edge.
  function automatic void modelStep(input bit arm, input bit clr, input bit r,
                                    input bit d, input bit rn);
    bit armEvt;
    int el;
    cyc++;
    if (!rn) begin
      mPrevArm   = arm;
      mPend      = 1'b0;
      mWaiting   = 1'b0;
      mMeasuring = 1'b0;
      mLag       = 0;
      mValid     = 1'b0;
      mOvf       = 1'b0;
      mRearmAt   = -1;
      return;
    end
    armEvt   = mPend;
    mPend    = arm && !mPrevArm;
    mPrevArm = arm;
    if (clr) begin
      mWaiting   = 1'b0;
      mMeasuring = 1'b0;
      mLag       = 0;
      mValid     = 1'b0;
      mOvf       = 1'b0;
      mRearmAt   = -1;
    end else if (armEvt) begin
      mWaiting   = 1'b1;
      mMeasuring = 1'b0;
      mLag       = 0;
      mValid     = 1'b0;
      mOvf       = 1'b0;
      mRearmAt   = -1;
    end else if (mWaiting) begin
      if (r && d) begin
        finishMeasure(0, 1'b0);
      end else if (r) begin
        mWaiting   = 1'b0;
        mMeasuring = 1'b1;
        mRefAt     = cyc;
      end
    end else if (mMeasuring) begin
      el = cyc - mRefAt;
      if (d) finishMeasure(el, 1'b0);
      else if (el == TIMEOUT) finishMeasure(TIMEOUT, 1'b1);
    end else if (mRearmAt == cyc) begin
      mWaiting = 1'b1;
    end
  endfunction

  function automatic logic [31:0] expWord();
    logic [31:0] w;
    w     = 32'(mLag);
    w[31] = mValid;
    w[30] = mOvf;
    return w;
  endfunction

  function automatic logic [31:0] mkLatch(input bit arm, input bit clr);
    logic [31:0] w;
    w    = $urandom();
    w[0] = arm;
    w[1] = clr;
    return w;
  endfunction

  // Compares both outputs against the model.
  task automatic checkOutput();
    logic [31:0] ew;
    logic        eb;
    ew = expWord();
    eb = mWaiting || mMeasuring;
    total++;
    assert (lag_out === ew) else begin
      bad++;
      $error("[TB] FAIL lag_out cyc=%0d: observed=%h expected=%h", cyc, lag_out, ew);
    end
    total++;
    assert (busy === eb) else begin
      bad++;
      $error("[TB] FAIL busy cyc=%0d: observed=%b expected=%b", cyc, busy, eb);
    end
  endtask

  // Compares an output against a value worked out by hand for a scenario.
  task automatic checkConst(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, steps the model at the edge, checks after it.
  task automatic applyStimulus(input logic [31:0] latch, input logic r,
                               input logic d, input logic rn);
    latch_reg  = latch;
    ref_sync   = r;
    dat_sync   = d;
    user_rst_n = rn;
    @(posedge user_clk);
    modelStep(latch[0], latch[1], r, d, rn);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n, input bit arm);
    for (int i = 0; i < n; i++) applyStimulus(mkLatch(arm, 1'b0), 1'b0, 1'b0, 1'b1);
  endtask

  // Low, rising edge, then the cycle on which the arm event takes effect.
  task automatic armPulse();
    applyStimulus(mkLatch(1'b0, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus(mkLatch(1'b1, 1'b0), 1'b0, 1'b0, 1'b1);
    applyStimulus(mkLatch(1'b1, 1'b0), 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bit armLvl;
    bit clrLvl;
    bit rn;
    bit r;
    bit d;
    int datRange;

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    checkConst("reset_lag", lag_out, 32'h0);
    checkConst("reset_busy", {31'b0, busy}, 32'h0);
    idle(2, 1'b0);

    $display("[TB] lag 5");
    armPulse();
    checkConst("armed_busy", {31'b0, busy}, 32'h1);
    idle(6, 1'b1);
    applyStimulus(mkLatch(1'b1, 1'b0), 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    applyStimulus(mkLatch(1'b1, 1'b0), 1'b0, 1'b1, 1'b1);
    checkConst("lag5_word", lag_out, 32'h80000005);
    checkConst("lag5_busy", {31'b0, busy}, 32'h0);
    applyStimulus(mkLatch(1'b1, 1'b0), 1'b1, 1'b1, 1'b1);
    checkConst("done_hold", lag_out, 32'h80000005);

    $display("[TB] simultaneous ref and dat");
    armPulse();
    idle(1, 1'b1);
    applyStimulus(mkLatch(1'b1, 1'b0), 1'b1, 1'b1, 1'b1);
    checkConst("lag0_word", lag_out, 32'h80000000);
    checkConst("lag0_busy", {31'b0, busy}, 32'h0);

    $display("[TB] timeout");
    armPulse();
    applyStimulus(mkLatch(1'b1, 1'b0), 1'b1, 1'b0, 1'b1);
    idle(TIMEOUT - 1, 1'b1);
    checkConst("pre_timeout_busy", {31'b0, busy}, 32'h1);
    idle(1, 1'b1);
    checkConst("timeout_word", lag_out, 32'hC0000064);

    $display("[TB] rearm mid-count");
    armPulse();
    applyStimulus(mkLatch(1'b1, 1'b0), 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    armPulse();
    applyStimulus(mkLatch(1'b1, 1'b0), 1'b1, 1'b0, 1'b1);
    idle(6, 1'b1);
    applyStimulus(mkLatch(1'b1, 1'b0), 1'b0, 1'b1, 1'b1);
    checkConst("rearm_word", lag_out, 32'h80000007);

    $display("[TB] clear in count");
    armPulse();
    applyStimulus(mkLatch(1'b1, 1'b0), 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);
    applyStimulus(mkLatch(1'b1, 1'b1), 1'b0, 1'b0, 1'b1);
    checkConst("clear_word", lag_out, 32'h0);
    checkConst("clear_busy", {31'b0, busy}, 32'h0);
    idle(3, 1'b1);

    $display("[TB] reset with arm held");
    for (int i = 0; i < 2; i++) applyStimulus(mkLatch(1'b1, 1'b0), 1'b0, 1'b0, 1'b0);
    idle(4, 1'b1);
    checkConst("no_arm_after_reset", {31'b0, busy}, 32'h0);
    armPulse();
    checkConst("arm_after_toggle", {31'b0, busy}, 32'h1);

    $display("[TB] random");
    armLvl = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) armLvl = ~armLvl;
      clrLvl   = ($urandom_range(0, 59) == 0);
      rn       = ($urandom_range(0, 399) != 0);
      datRange = (i < 2000) ? 8 : 150;
      r        = ($urandom_range(0, 5) == 0);
      d        = ($urandom_range(0, datRange) == 0);
      applyStimulus(mkLatch(armLvl, clrLvl), r, d, rn);
    end

`ifdef CHECK_LAG_AUTO_REARM_EN
    $display("[TB] auto rearm");
    armPulse();
    idle(2, 1'b1);
    applyStimulus(mkLatch(1'b1, 1'b0), 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);
    applyStimulus(mkLatch(1'b1, 1'b0), 1'b0, 1'b1, 1'b1);
    checkConst("auto_first", lag_out, 32'h80000003);
    idle(2, 1'b1);
    checkConst("auto_hold", lag_out, 32'h80000003);
    checkConst("auto_busy", {31'b0, busy}, 32'h1);
    applyStimulus(mkLatch(1'b1, 1'b0), 1'b1, 1'b0, 1'b1);
    idle(8, 1'b1);
    applyStimulus(mkLatch(1'b1, 1'b0), 1'b0, 1'b1, 1'b1);
    checkConst("auto_second", lag_out, 32'h80000009);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
